// File: rtl/scan_ram_ctrl.sv
// Data RAM with power-up zero-fill, synchronised button capture into one word
// and a free-running LED row scanner; CPU access is registered and arbitrated.
//   state | meaning
//   CLEAR | zero-fill walks every word, CPU requests dropped, busy=1
//   RUN   | normal CPU/button/scan operation until reset
module scan_ram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int IN_ADDR   = 0,
  parameter int SCAN_BASE = 0,
  parameter int SCAN_ROWS = 8,
  parameter int SCAN_DIV  = 4,
  localparam int RIDX_W   = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic              btn_strobe,
  input  logic [DATA_W-1:0] btn_data,
  output logic [DATA_W-1:0] row,
  output logic [RIDX_W-1:0] row_idx
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_next;
  logic clear_en;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [MEM_AW-1:0] clr_ptr;
  logic [MEM_AW-1:0] cpu_idx;
  logic [MEM_AW-1:0] scan_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic              addr_ok, cpu_wr, cpu_rd;
  logic              sync1, sync2, sync_prev;
  logic [DATA_W-1:0] bdata1, bdata2, btn_val;
  logic              pending, btn_edge, btn_commit;

  assign addr_ok    = {1'b0, addr} < DEPTH_L;
  assign cpu_idx    = addr[MEM_AW-1:0];
  assign cpu_wr     = !busy && we && addr_ok;
  assign cpu_rd     = !busy && oe && !we;
  assign btn_edge   = sync2 && !sync_prev;
  assign btn_commit = !busy && !we && pending;
  assign scan_idx   = MEM_AW'(SCAN_BASE) + MEM_AW'(row_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_ptr == MEM_AW'(DEPTH-1)) state_next = RUN;
  end

  always_comb begin
    busy     = 1'b0;
    clear_en = 1'b0;
    if (state == CLEAR) begin
      busy     = 1'b1;
      clear_en = 1'b1;
    end
  end

  // Single write port: zero-fill, then CPU, then the pending button value.
  always_ff @(posedge clk) begin
    if (clear_en)        mem[clr_ptr] <= '0;
    else if (cpu_wr)     mem[cpu_idx] <= wdata;
    else if (btn_commit) mem[MEM_AW'(IN_ADDR)] <= btn_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        clr_ptr <= '0;
    else if (clear_en) clr_ptr <= clr_ptr + MEM_AW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= cpu_rd;
      if (cpu_rd) rdata <= addr_ok ? mem[cpu_idx] : '0;
    end
  end

  // Button data rides alongside the strobe synchroniser so both line up at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      bdata1    <= '0;
      bdata2    <= '0;
      btn_val   <= '0;
      pending   <= 1'b0;
    end else begin
      sync1     <= btn_strobe;
      sync2     <= sync1;
      sync_prev <= sync2;
      bdata1    <= btn_data;
      bdata2    <= bdata1;
      if (btn_edge) begin
        pending <= 1'b1;
        btn_val <= bdata2;
      end else if (btn_commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      row_idx <= '0;
      row     <= '0;
    end else if (busy) begin
      div_cnt <= '0;
      row_idx <= '0;
      row     <= '0;
    end else begin
      row <= mem[scan_idx];
      if (div_cnt == DIV_W'(SCAN_DIV-1)) begin
        div_cnt <= '0;
        row_idx <= (row_idx == RIDX_W'(SCAN_ROWS-1)) ? '0 : row_idx + RIDX_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scan_ram_ctrl.sv
// Bench for scan_ram_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-count based reference model.
module tb_scan_ram_ctrl;
  localparam int DATA_W = 8, ADDR_W = 9, DEPTH = 256, IN_ADDR = 0;
  localparam int SCAN_BASE = 0, SCAN_ROWS = 8, SCAN_DIV = 4;

  logic clk = 1'b0, reset = 1'b0, we = 1'b0, oe = 1'b0, btn_strobe = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0, btn_data = '0;
  logic [DATA_W-1:0] rdata, row;
  logic rvalid, busy;
  logic [2:0] row_idx;

  int checks = 0, errors = 0;

  logic [7:0] m_mem [DEPTH];
  int         m_since;
  logic       m_pend;
  logic [7:0] m_pval;
  logic [2:0] h_s;
  logic [7:0] h_d [3];
  logic [7:0] e_rdata, e_row;
  logic       e_rvalid, e_busy;
  int         e_idx;

  scan_ram_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IN_ADDR(IN_ADDR),
    .SCAN_BASE(SCAN_BASE), .SCAN_ROWS(SCAN_ROWS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .btn_strobe(btn_strobe),
    .btn_data(btn_data), .row(row), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_since  = 0;
    m_pend   = 1'b0;
    m_pval   = '0;
    h_s      = '0;
    for (int i = 0; i < 3; i++) h_d[i] = '0;
    e_rdata  = '0;
    e_rvalid = 1'b0;
    e_busy   = 1'b1;
    e_row    = '0;
    e_idx    = 0;
  endtask

  // Evaluated at each active edge using the inputs present at that edge.
  task automatic model_edge();
    int  n;
    bit  bedge;
    logic [7:0] bval;
    bedge = h_s[1] && !h_s[2];
    bval  = h_d[1];
    if (m_since < DEPTH) begin
      m_mem[m_since] = '0;
      e_rvalid = 1'b0;
      e_row    = '0;
      e_idx    = 0;
    end else begin
      n     = m_since - DEPTH;
      e_row = m_mem[SCAN_BASE + (n / SCAN_DIV) % SCAN_ROWS];
      if (oe && !we) begin
        e_rdata  = (int'(addr) < DEPTH) ? m_mem[addr[7:0]] : 8'h00;
        e_rvalid = 1'b1;
      end else begin
        e_rvalid = 1'b0;
      end
      if (we) begin
        if (int'(addr) < DEPTH) m_mem[addr[7:0]] = wdata;
      end else if (m_pend) begin
        m_mem[IN_ADDR] = m_pval;
        m_pend = 1'b0;
      end
      e_idx = ((n + 1) / SCAN_DIV) % SCAN_ROWS;
    end
    if (bedge) begin
      m_pend = 1'b1;
      m_pval = bval;
    end
    h_s  = {h_s[1:0], btn_strobe};
    h_d[2] = h_d[1];
    h_d[1] = h_d[0];
    h_d[0] = btn_data;
    m_since++;
    e_busy = (m_since < DEPTH);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rdata",   32'(rdata),   32'(e_rdata));
    check("rvalid",  32'(rvalid),  32'(e_rvalid));
    check("busy",    32'(busy),    32'(e_busy));
    check("row",     32'(row),     32'(e_row));
    check("row_idx", 32'(row_idx), e_idx);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"},   32'(rdata),   32'h0);
    check({tag, "_rvalid"},  32'(rvalid),  32'h0);
    check({tag, "_busy"},    32'(busy),    32'h1);
    check({tag, "_row"},     32'(row),     32'h0);
    check({tag, "_row_idx"}, 32'(row_idx), 32'h0);
  endtask

  task automatic idle();
    we = 1'b0; oe = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    logic [2:0] prev_idx;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    model_reset();

    // Random CPU traffic during the zero-fill must be dropped.
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      we = 1'($urandom_range(0, 1));
      oe = 1'($urandom_range(0, 1));
      addr = ADDR_W'($urandom_range(0, 511));
      wdata = 8'($urandom);
      step();
      if (busy) busy_cycles++;
    end
    check("busy_len", 32'(busy_cycles), 32'(DEPTH - 1));

    idle();
    for (int a = 0; a < 8; a++) begin
      oe = 1'b1; addr = ADDR_W'(a * 37);
      step();
      check("clear_read", 32'(rdata), 32'h0);
    end

    we = 1'b1; oe = 1'b0; addr = 9'h010; wdata = 8'hA5;
    step();
    we = 1'b0; oe = 1'b1;
    step();
    check("wr_then_rd", 32'(rdata), 32'hA5);
    check("wr_then_rd_v", 32'(rvalid), 32'h1);
    idle();
    step();
    check("rvalid_drop", 32'(rvalid), 32'h0);
    check("rdata_hold", 32'(rdata), 32'hA5);

    // CPU write to IN_ADDR overlapping two button edges; latest button value wins.
    we = 1'b1; addr = ADDR_W'(IN_ADDR); wdata = 8'h77;
    btn_strobe = 1'b1; btn_data = 8'h11;
    step(); step();
    btn_strobe = 1'b0;
    step();
    btn_strobe = 1'b1; btn_data = 8'h22;
    step(); step(); step();
    we = 1'b0; oe = 1'b1;
    step();
    check("btn_before_commit", 32'(rdata), 32'h77);
    btn_strobe = 1'b0;
    step();
    check("btn_latest", 32'(rdata), 32'h22);

    idle();
    we = 1'b1; addr = ADDR_W'(SCAN_BASE + 2); wdata = 8'h3C;
    step();
    idle();
    prev_idx = row_idx;
    for (int i = 0; i < 40; i++) begin
      step();
      if (row_idx == 3'd2 && prev_idx == 3'd2) check("scan_row2", 32'(row), 32'h3C);
      prev_idx = row_idx;
    end

    we = 1'b1; addr = 9'h1F0; wdata = 8'h5A;
    step();
    we = 1'b0; oe = 1'b1;
    step();
    check("oob_rdata", 32'(rdata), 32'h0);
    check("oob_rvalid", 32'(rvalid), 32'h1);
    addr = 9'h0F0;
    step();
    check("oob_alias", 32'(rdata), 32'h0);

    for (int i = 0; i < 1500; i++) begin
      we = ($urandom_range(0, 3) == 0);
      oe = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(0, 511))
                                         : ADDR_W'($urandom_range(0, 15));
      wdata = 8'($urandom);
      if (!btn_strobe) begin
        btn_data = 8'($urandom);
        if ($urandom_range(0, 5) == 0) btn_strobe = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        btn_strobe = 1'b0;
      end
      step();
    end

    // Reset while a write is being presented.
    we = 1'b1; oe = 1'b0; addr = 9'h005; wdata = 8'h99;
    #2;
    reset = 1'b0;
    btn_strobe = 1'b0;
    #1;
    check_reset_outputs("midrun");
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH + 2; i++) step();
    for (int a = 0; a < DEPTH; a++) begin
      oe = 1'b1; addr = ADDR_W'(a);
      step();
      check("reclear", 32'(rdata), 32'h0);
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
